// File: rtl/fp12_pkg.sv
// Shared definitions for the 12-bit sign-ignored float format:
// [11] sign (ignored), [10:7] exponent, [6:0] mantissa with a hidden leading 1.
package fp12_pkg;

  localparam int FP_W     = 12;
  localparam int EXP_W    = 4;
  localparam int MAN_W    = 7;

  // Field slices inside a 12-bit word
  localparam int SIGN_BIT = 11;
  localparam int EXP_HI   = 10;
  localparam int EXP_LO   = 7;
  localparam int MAN_HI   = 6;
  localparam int MAN_LO   = 0;

  // Significand = hidden one + mantissa; the raw sum needs one carry bit more
  localparam int SIG_W    = MAN_W + 1;
  localparam int SUM_W    = MAN_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [FP_W-1:0]  SAT_VAL = 12'h7FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMP,
    ST_ALIGN,
    ST_ADD,
    ST_DONE
  } fadd_state_e;

  // Magnitude part of an operand (sign stripped)
  typedef struct packed {
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
  } fp_mag_t;

  // Build a magnitude from the low 11 bits of a word
  function automatic fp_mag_t mag_of(input logic [EXP_HI:MAN_LO] v);
    return fp_mag_t'(v);
  endfunction

endpackage

// File: rtl/fadd_core.sv
// Combinational add / normalize / saturate step used in the ADD state.
// Inputs are the big operand and the already-aligned small significand.
module fadd_core
  import fp12_pkg::*;
(
  input  fp_mag_t          big,
  input  logic [SIG_W-1:0] small_sig,
  output logic [FP_W-1:0]  z,
  output logic             ovf
);

  logic [SUM_W-1:0] sum;
  logic [EXP_W-1:0] exp_inc;

  // Add the significands, then renormalize by at most one position
  always_comb begin
    sum     = {1'b0, 1'b1, big.man} + {1'b0, small_sig};
    exp_inc = big.expo + EXP_W'(1);
    z       = '0;
    ovf     = 1'b0;
    if (sum[SUM_W-1]) begin
      if (big.expo == EXP_MAX) begin
        // Carry out of the top exponent: clamp to the largest value
        z   = SAT_VAL;
        ovf = 1'b1;
      end else begin
        // Carry: bump exponent, drop the sum LSB
        z = {1'b0, exp_inc, sum[MAN_W:1]};
      end
    end else begin
      z = {1'b0, big.expo, sum[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/fadd_seq.sv
// Multi-cycle 12-bit magnitude adder: IDLE -> CMP -> ALIGN* -> ADD -> DONE.
// ALIGN_STEP bit positions (1, 2 or 4) are shifted per ALIGN cycle.
// Optional feature macro FADD_ACC_EN: accumulator operand (acc_en/acc_clr)
// and back-to-back accept from DONE.
module fadd_seq
  import fp12_pkg::*;
#(
  parameter int ALIGN_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] x,
  input  logic [FP_W-1:0] y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] z,
  output logic            ovf,
  output logic            busy
`ifdef FADD_ACC_EN
  ,
  input  logic            acc_en,
  input  logic            acc_clr
`endif
);

  localparam logic [EXP_W-1:0] STEP  = EXP_W'(ALIGN_STEP);
  // Exponent gap at which the small operand shifts out completely
  localparam logic [EXP_W-1:0] FAR_D = EXP_W'(SIG_W);

  fadd_state_e      state_q, state_d;
  fp_mag_t          op_x_q, op_y_q, big_q;
  logic [SIG_W-1:0] sm_q;
  logic [EXP_W-1:0] d_q;
  logic [FP_W-1:0]  z_q, core_z;
  logic             ovf_q, core_ovf;
  logic             accept;
  logic             b2b_ok;
  logic             pass_q;
  fp_mag_t          x_eff;

  // CMP-stage comb results
  logic             swap;
  fp_mag_t          big_c, small_c;
  logic [EXP_W-1:0] diff_c, d_load;
  logic [SIG_W-1:0] small_sig;
  logic [EXP_W-1:0] shamt;

  // Sign bits are carried on the ports but play no part in the magnitude sum
  logic unused_sign;
  assign unused_sign = x[SIGN_BIT] ^ y[SIGN_BIT];

  assign accept = in_valid && in_ready;

`ifdef FADD_ACC_EN
  fp_mag_t acc_q, acc_d;
  logic    acc_full_q, acc_full_d;
  logic    deliver;

  assign deliver = out_valid && out_ready;
  assign b2b_ok  = 1'b1;

  // Next accumulator contents: delivered results load it, clear wins
  always_comb begin
    acc_d      = acc_q;
    acc_full_d = acc_full_q;
    if (deliver) begin
      acc_d      = mag_of(z_q[EXP_HI:MAN_LO]);
      acc_full_d = 1'b1;
    end
    if (acc_clr) acc_full_d = 1'b0;
  end

  // Accumulator register; pass_q marks "empty accumulator, result is y"
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      acc_full_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_full_q <= acc_full_d;
      if (accept) pass_q <= acc_en && !acc_full_d;
    end
  end

  // Operand x source; uses the accumulator value as updated this cycle so a
  // back-to-back accept chains on the result being delivered right now
  always_comb begin
    x_eff = mag_of(x[EXP_HI:MAN_LO]);
    if (acc_en && acc_full_d) x_eff = acc_d;
  end
`else
  assign b2b_ok = 1'b0;
  assign pass_q = 1'b0;
  assign x_eff  = mag_of(x[EXP_HI:MAN_LO]);
`endif

  // Order operands by exponent and derive the alignment work for ALIGN
  always_comb begin
    swap      = op_y_q.expo > op_x_q.expo;
    big_c     = swap ? op_y_q : op_x_q;
    small_c   = swap ? op_x_q : op_y_q;
    diff_c    = big_c.expo - small_c.expo;
    small_sig = {1'b1, small_c.man};
    d_load    = diff_c;
    if (diff_c >= FAR_D) begin
      small_sig = '0;
      d_load    = '0;
    end
    if (pass_q) begin
      big_c     = op_y_q;
      small_sig = '0;
      d_load    = '0;
    end
    shamt = (d_q < STEP) ? d_q : STEP;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CMP;
      ST_CMP:   state_d = (d_load == '0) ? ST_ADD : ST_ALIGN;
      ST_ALIGN: if (d_q <= STEP) state_d = ST_ADD;
      ST_ADD:   state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = accept ? ST_CMP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state_q == ST_IDLE) ||
                (b2b_ok && (state_q == ST_DONE) && out_ready);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // Datapath: capture operands, align the small significand, latch result
  always_ff @(posedge clk) begin
    if (rst) begin
      op_x_q <= '0;
      op_y_q <= '0;
      big_q  <= '0;
      sm_q   <= '0;
      d_q    <= '0;
      z_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_x_q <= x_eff;
        op_y_q <= mag_of(y[EXP_HI:MAN_LO]);
      end
      case (state_q)
        ST_CMP: begin
          big_q <= big_c;
          sm_q  <= small_sig;
          d_q   <= d_load;
        end
        ST_ALIGN: begin
          // Shifted-out bits are simply dropped (truncation)
          sm_q <= sm_q >> shamt;
          d_q  <= d_q - shamt;
        end
        ST_ADD: begin
          z_q   <= core_z;
          ovf_q <= core_ovf;
        end
        default: ;
      endcase
    end
  end

  fadd_core u_core (
    .big       (big_q),
    .small_sig (sm_q),
    .z         (core_z),
    .ovf       (core_ovf)
  );

  assign z   = z_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_fadd_seq.sv
// Self-checking bench for fadd_seq: arithmetic model + scoreboard queue,
// one compare process on the falling edge, directed hand-computed vectors.
`timescale 1ns/1ps
module tb_fadd_seq;

  localparam int STEP = 1;
  localparam int NV   = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic        in_ready, out_valid, ovf, busy;
  logic [11:0] z;
`ifdef FADD_ACC_EN
  logic        acc_en = 1'b0;
  logic        acc_clr = 1'b0;
`endif

  fadd_seq #(.ALIGN_STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .ovf       (ovf),
    .busy      (busy)
`ifdef FADD_ACC_EN
    ,
    .acc_en    (acc_en),
    .acc_clr   (acc_clr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] z;
    logic        o;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] z;
    logic        o;
    int          l;
  } vec_t;

  // Hand-computed vectors (latencies for STEP = 1)
  vec_t vt [NV] = '{
    '{12'h180, 12'h180, 12'h200, 1'b0, 2},
    '{12'h100, 12'h200, 12'h220, 1'b0, 4},
    '{12'h780, 12'h000, 12'h780, 1'b0, 2},
    '{12'h7FF, 12'h7FF, 12'h7FF, 1'b1, 2},
    '{12'h980, 12'h180, 12'h200, 1'b0, 2},
    '{12'h205, 12'h183, 12'h246, 1'b0, 3},
    '{12'h000, 12'h3FF, 12'h400, 1'b0, 9},
    '{12'h400, 12'h07F, 12'h400, 1'b0, 2},
    '{12'h3C0, 12'h3C0, 12'h440, 1'b0, 2},
    '{12'h780, 12'h700, 12'h7C0, 1'b0, 3},
    '{12'h7C0, 12'h740, 12'h7FF, 1'b1, 3},
    '{12'h740, 12'h740, 12'h7C0, 1'b0, 2},
    '{12'h101, 12'h081, 12'h141, 1'b0, 3},
    '{12'h181, 12'h180, 12'h200, 1'b0, 2}
  };

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Value-level model: value = 1.m * 2^e, smaller one scaled down by 2^d
  function automatic void model(input logic [11:0] a, input logic [11:0] b,
                                output logic [11:0] zz, output logic ov, output int lat);
    int ea, eb, ma, mb, eg, mg, ms, d, s, sum;
    ea = int'(a[10:7]);
    eb = int'(b[10:7]);
    ma = 128 + int'(a[6:0]);
    mb = 128 + int'(b[6:0]);
    if (eb > ea) begin eg = eb; mg = mb; ms = ma; d = eb - ea; end
    else         begin eg = ea; mg = ma; ms = mb; d = ea - eb; end
    s   = (d >= 8) ? 0 : (ms >> d);
    sum = mg + s;
    ov  = 1'b0;
    if (sum >= 256) begin
      if (eg == 15) begin zz = 12'h7FF; ov = 1'b1; end
      else zz = 12'((eg + 1) * 128 + (sum / 2 - 128));
    end else begin
      zz = 12'(eg * 128 + sum - 128);
    end
    lat = (d > 0 && d < 8) ? 2 + (d + STEP - 1) / STEP : 2;
  endfunction

  // Compare process: every cycle, outputs against the scoreboard head
  always @(negedge clk) begin
    bit inflight, ov_exp, rdy_exp;
    if (chk_en && !rst) begin
      inflight = (q.size() > 0) && (cyc >= q[0].acc);
      ov_exp   = inflight && (cyc >= q[0].acc + q[0].lat);
      rdy_exp  = !inflight;
`ifdef FADD_ACC_EN
      if (ov_exp && out_ready) rdy_exp = 1'b1;
`endif
      chk("out_valid", 32'(out_valid), 32'(ov_exp));
      chk("busy", 32'(busy), 32'(inflight));
      chk("in_ready", 32'(in_ready), 32'(rdy_exp));
      if (ov_exp) begin
        chk("z", 32'(z), 32'(q[0].z));
        chk("ovf", 32'(ovf), 32'(q[0].o));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] a, input logic [11:0] b);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      n_chk++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      return;
    end
    x = a; y = b; in_valid = 1'b1;
    model(a, b, e.z, e.o, e.lat);
    e.acc = cyc + 1;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 60) begin tick(); n++; end
    if (q.size() > 0) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [11:0] mz;
    logic        mo;
    int          ml;
    int          n;

    // Pin the model to the hand-computed table
    for (int i = 0; i < NV; i++) begin
      model(vt[i].a, vt[i].b, mz, mo, ml);
      chk($sformatf("model_z[%0d]", i), 32'(mz), 32'(vt[i].z));
      chk($sformatf("model_ovf[%0d]", i), 32'(mo), 32'(vt[i].o));
      chk($sformatf("model_lat[%0d]", i), 32'(ml), 32'(vt[i].l));
    end

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_z", 32'(z), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Directed vectors, one at a time
    for (int i = 0; i < NV; i++) begin
      send(vt[i].a, vt[i].b);
      drain();
    end

    // Back-pressure: result held for 5 cycles while a new pair is offered
    out_ready = 1'b0;
    send(12'h205, 12'h183);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("bp_out_valid", 32'(out_valid), 32'(1));
    in_valid = 1'b1; x = 12'h7FF; y = 12'h7FF;
    repeat (5) tick();
    chk("bp_held_z", 32'(z), 32'(12'h246));
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of ALIGN: the result must never appear
    send(12'h000, 12'h3FF);
    repeat (2) tick();
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    repeat (15) tick();
    send(12'h100, 12'h200);
    drain();

`ifdef FADD_ACC_EN
    // Accumulator: empty -> passes y through, then adds onto the last result
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    acc_en = 1'b1;
    send(12'h7FF, 12'h180);
    q[q.size()-1].z = 12'h180; q[q.size()-1].o = 1'b0; q[q.size()-1].lat = 2;
    drain();
    send(12'h000, 12'h180);
    q[q.size()-1].z = 12'h200; q[q.size()-1].o = 1'b0; q[q.size()-1].lat = 2;
    drain();
    acc_en = 1'b0;
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
